// File: rtl/booth_pkg.sv
// booth_pkg: shared state and operation encodings for the Booth multiplier family
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [1:0] {NOP, ADD, SUB} op_t;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/subtract plus arithmetic right shift of the accumulator
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] m,
    input  logic           q0,
    input  logic           q_1,
    output logic [WIDTH:0] a_next,
    output logic           shift_in
);

    op_t            op;
    logic [WIDTH:0] sum;

    // Decode the bit pair, apply it, then shift; the bit falling out of A enters Q's MSB.
    always_comb begin
        op       = ({q0, q_1} == 2'b01) ? ADD : ({q0, q_1} == 2'b10) ? SUB : NOP;
        sum      = (op == ADD) ? a + m : (op == SUB) ? a - m : a;
        a_next   = {sum[WIDTH], sum[WIDTH:1]};
        shift_in = sum[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential signed radix-2 Booth multiplier, one step per clock
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = clog2(WIDTH + 1);

    state_t             state, state_n;
    logic [WIDTH:0]     a, a_n, m, m_n, a_step;
    logic [WIDTH-1:0]   q, q_n;
    logic               q_1, q_1_n, shift_in, done_n;
    logic [CW-1:0]      count, count_n;
    logic [2*WIDTH-1:0] product_n;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a        (a),
        .m        (m),
        .q0       (q[0]),
        .q_1      (q_1),
        .a_next   (a_step),
        .shift_in (shift_in)
    );

    assign busy = (state != IDLE);

    // Next-state and datapath update; registers hold unless the current state changes them.
    always_comb begin
        state_n   = state;
        a_n       = a;
        m_n       = m;
        q_n       = q;
        q_1_n     = q_1;
        count_n   = count;
        product_n = product;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    m_n     = {multiplicand[WIDTH-1], multiplicand};
                    a_n     = '0;
                    q_n     = multiplier;
                    q_1_n   = 1'b0;
                    count_n = CW'(WIDTH);
                end
            end
            RUN: begin
                a_n     = a_step;
                q_n     = {shift_in, q[WIDTH-1:1]};
                q_1_n   = q[0];
                count_n = count - CW'(1);
                state_n = (count_n == '0) ? DONE : RUN;
            end
            DONE: begin
                product_n = {a[WIDTH-1:0], q};
                done_n    = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            m       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            a       <= a_n;
            m       <= m_n;
            q       <= q_n;
            q_1     <= q_1_n;
            count   <= count_n;
            product <= product_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: scoreboard bench comparing the multiplier against plain signed arithmetic
module tb_booth_seq_multiplier;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] p;
        int             c;
    } exp_t;

    logic           clk, rst, start, busy, done;
    logic [W-1:0]   multiplier, multiplicand;
    logic [2*W-1:0] product, last_prod;
    exp_t           sb[$];
    int             cyc, checks, errors;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        longint p;
        p = longint'(x) * longint'(y);
        return p[2*W-1:0];
    endfunction

    // Monitor: checks busy window, done timing/value, and result persistence every cycle.
    always @(posedge clk) begin
        logic exp_busy;
        exp_t e;
        cyc++;
        #1;
        exp_busy = 1'b0;
        foreach (sb[i]) if (cyc >= sb[i].c - W - 1 && cyc <= sb[i].c - 1) exp_busy = 1'b1;
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cyc=%0d got=1 exp=0", cyc);
            end else begin
                e = sb.pop_front();
                checks += 2;
                if (product !== e.p) begin
                    errors++;
                    $display("FAIL product cyc=%0d got=%h exp=%h", cyc, product, e.p);
                end
                if (cyc != e.c) begin
                    errors++;
                    $display("FAIL done_time got=%0d exp=%0d", cyc, e.c);
                end
                last_prod = e.p;
            end
        end else begin
            if (sb.size() > 0 && cyc >= sb[0].c) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_done cyc=%0d got=0 exp=1", cyc);
            end
            checks++;
            if (product !== last_prod) begin
                errors++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, product, last_prod);
            end
        end
    end

    // Call at a falling edge; waits for IDLE, presents one start, returns one falling edge later.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL idle_wait got=%b exp=0", busy);
        end
        start        = 1'b1;
        multiplier   = x;
        multiplicand = y;
        sb.push_back('{ref_mul(x, y), cyc + W + 2});
        @(negedge clk);
        start        = 1'b0;
        multiplier   = W'($urandom);
        multiplicand = W'($urandom);
    endtask

    // Raise start for one cycle while an operation is known to be in flight.
    task automatic stray_start(input int after);
        repeat (after) @(negedge clk);
        start        = 1'b1;
        multiplier   = W'($urandom);
        multiplicand = W'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        last_prod    = '0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        issue(W'(-128), W'(-128));
        issue(W'(127), W'(-128));
        issue(W'(-128), W'(127));
        issue(W'(127), W'(127));
        issue(W'(1), W'(0));
        issue(W'(-1), W'(-1));
        issue(W'(45), W'(-7));
        stray_start(2);
        issue(W'(-100), W'(3));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        last_prod = '0;
        @(negedge clk);
        rst = 1'b0;
        issue(W'(-77), W'(91));
        while (busy !== 1'b0) @(negedge clk);
        start        = 1'b1;
        multiplier   = W'(-3);
        multiplicand = W'(5);
        for (int i = 0; i < 3; i++) sb.push_back('{ref_mul(W'(-3), W'(5)), cyc + W + 2 + i * (W + 2)});
        repeat (22) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom));
            if ($urandom_range(3) == 0) stray_start($urandom_range(W - 2));
            else repeat ($urandom_range(W + 3)) @(negedge clk);
        end
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
